matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter ELEM_W, default 32, SHALL set the element width in bits.
REQ-002 Parameter MAX_DIM, default 16, SHALL set the maximum rows or columns per matrix.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cfg_valid  input  1  SHALL indicate a dimension set is offered.
REQ-006 cfg_ready  output  1  SHALL indicate the block accepts a dimension set.
REQ-007 cfg_ax, cfg_ay, cfg_bx, cfg_by  input  8 each  SHALL carry A columns, A rows, B columns and B rows.
REQ-008 s_valid  input  1  SHALL indicate an element is offered.
REQ-009 s_ready  output  1  SHALL indicate the block accepts an element.
REQ-010 s_data  input  ELEM_W  SHALL carry one matrix element.
REQ-011 inA, inB  output  ELEM_W*MAX_DIM*MAX_DIM (8192)  SHALL carry the flattened A and B matrices to the multiplier.
REQ-012 Ax, Ay, Bx, By  output  8 each  SHALL carry the registered dimensions to the multiplier.
REQ-013 enable  output  1  SHALL request a multiply and stay high until the multiplier finishes.
REQ-014 done  input  1  SHALL be the multiplier completion flag.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.
REQ-016 err  output  1  SHALL be a one-cycle pulse when a dimension set is rejected.

Function
REQ-017 The state machine SHALL have the states IDLE, LOAD_A, LOAD_B, RUN and ERR.
REQ-018 A handshake SHALL occur on a rising edge where valid and ready are both high; no other edge SHALL transfer data.
REQ-019 cfg_ready SHALL be high only in IDLE; s_ready SHALL be high only in LOAD_A and LOAD_B.
REQ-020 On a cfg handshake the block SHALL register the four dimensions and zero inA and inB.
REQ-021 The cfg handshake SHALL then move to ERR if any dimension is 0, any dimension exceeds MAX_DIM, or cfg_ax != cfg_by.
REQ-022 Otherwise the cfg handshake SHALL move to LOAD_A.
REQ-023 ERR SHALL last exactly one cycle with err=1, SHALL then return to IDLE, and SHALL leave Ax/Ay/Bx/By holding the rejected values.
REQ-024 Elements SHALL arrive row-major; element k of A SHALL be written to inA bits [k*ELEM_W +: ELEM_W], with k = row*Ax + col. The same rule SHALL apply to B using Bx.
REQ-025 A 9-bit element counter SHALL increment per handshake and clear on every state entry.
REQ-026 The handshake carrying the last A element (count Ax*Ay-1) SHALL move to LOAD_B.
REQ-027 The handshake carrying the last B element (count Bx*By-1) SHALL move to RUN.
REQ-028 enable SHALL rise in the cycle after the last B handshake, i.e. 1-cycle latency.
REQ-029 In RUN, enable SHALL stay high and inA/inB/dimensions SHALL stay stable until done=1 is sampled.
REQ-030 Sampling done=1 in RUN SHALL return the block to IDLE with enable=0 on the next cycle.
REQ-031 done SHALL be ignored outside RUN.
REQ-032 s_valid held high across the LOAD_A→LOAD_B transition SHALL lose or duplicate no element.
REQ-033 Bits beyond the loaded element count SHALL remain zero.
REQ-034 A 1x1 matrix SHALL complete its load in one handshake.
REQ-035 Dimension set 16x16 SHALL require exactly 256 handshakes per matrix.

Reset
REQ-036 reset low SHALL immediately force IDLE, counter=0, inA=inB=0, Ax=Ay=Bx=By=0, enable=0, err=0, busy=0, s_ready=0, and cfg_ready=1 after release.
REQ-037 reset asserted mid-load or in RUN SHALL discard all partial data; the next operation SHALL start from a cfg handshake.

Structure
REQ-038 A shared package matmul_pkg SHALL hold ELEM_W, MAX_DIM, the flat bus width constant and the loader state enum; the multiplier SHALL use the same package.
REQ-039 One sub-module, matrix_elem_writer, SHALL hold one flat ELEM_W*MAX_DIM*MAX_DIM register with clear, write-enable and index inputs, and SHALL be instantiated once for A and once for B.

Verification
REQ-040 Dimensions 2x2/2x2, A elements 1,2,3,4, B elements 5,6,7,8 -> inA[127:0]=0x00000004_00000003_00000002_00000001, inB likewise holds 8,7,6,5, and enable rises one cycle after the 8th handshake.
REQ-041 cfg_ax=3, cfg_by=2 -> err pulses for exactly one cycle, no s_ready, and the block returns to IDLE.
REQ-042 Dimensions 0 or 17 -> ERR; 16x16 streamed at full rate -> 512 handshakes, then enable.
REQ-043 s_valid toggled randomly during LOAD_A -> element order and positions are identical to the full-rate result.
REQ-044 reset pulsed low after 3 A elements, then a fresh 1x1/1x1 load of 7 and 9 -> inA[31:0]=7, inB[31:0]=9, upper bits zero.
REQ-045 In RUN, hold done=0 for 10 cycles then pulse it -> enable stays high 10+ cycles, falls the cycle after done, and cfg_ready returns.

Source files
------------

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : matmul_pkg
//  Description : Constants, loader state encoding and a dimension helper
//                shared by the matrix loader and the matrix multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int ELEM_W  = 32;                          // element width in bits
    localparam int MAX_DIM = 16;                          // max rows / columns per matrix
    localparam int FLAT_W  = ELEM_W * MAX_DIM * MAX_DIM;  // flattened matrix bus width
    localparam int DIM_W   = 8;                           // width of one dimension field
    localparam int CNT_W   = 9;                           // element counter width (0..256)

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERR    = 3'd4
    } loader_state_e;

    // A dimension is usable when it is non-zero and no larger than max_dim.
    function automatic logic dim_ok(input logic [DIM_W-1:0] d, input int max_dim);
        return (d != '0) && (int'(d) <= max_dim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_loader_if.sv
`default_nettype none
// ============================================================================
//  Interface   : matrix_loader_if
//  Description : Groups the configuration handshake, the element stream and
//                the multiplier-facing bus of the matrix loader.
//  Ports       : slave  - the loader side (consumes cfg/stream, drives bus)
//                master - the producer / multiplier side
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_loader_if #(
    parameter int ELEM_W  = matmul_pkg::ELEM_W,
    parameter int MAX_DIM = matmul_pkg::MAX_DIM
);
    localparam int BUS_W = ELEM_W * MAX_DIM * MAX_DIM;

    // dimension-set handshake
    logic              cfg_valid;
    logic              cfg_ready;
    logic [7:0]        cfg_ax;
    logic [7:0]        cfg_ay;
    logic [7:0]        cfg_bx;
    logic [7:0]        cfg_by;
    // element stream
    logic              s_valid;
    logic              s_ready;
    logic [ELEM_W-1:0] s_data;
    // multiplier-facing bus
    logic [BUS_W-1:0]  inA;
    logic [BUS_W-1:0]  inB;
    logic [7:0]        Ax;
    logic [7:0]        Ay;
    logic [7:0]        Bx;
    logic [7:0]        By;
    logic              enable;
    logic              done;
    // status
    logic              busy;
    logic              err;

    modport slave (
        input  cfg_valid, cfg_ax, cfg_ay, cfg_bx, cfg_by,
        input  s_valid, s_data, done,
        output cfg_ready, s_ready,
        output inA, inB, Ax, Ay, Bx, By, enable, busy, err
    );

    modport master (
        output cfg_valid, cfg_ax, cfg_ay, cfg_bx, cfg_by,
        output s_valid, s_data, done,
        input  cfg_ready, s_ready,
        input  inA, inB, Ax, Ay, Bx, By, enable, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/matrix_elem_writer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_elem_writer
//  Description : One flattened matrix register. Element idx occupies bits
//                [idx*ELEM_W +: ELEM_W]. clr zeroes the whole matrix and has
//                priority over a write.
//  Ports       : clk, reset (async, active-low)
//                clr   - zero all elements
//                we    - write wdata at element idx
//                idx   - element index (row-major)
//                wdata - element value
//                q     - flattened matrix contents
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_elem_writer #(
    parameter int ELEM_W  = matmul_pkg::ELEM_W,
    parameter int MAX_DIM = matmul_pkg::MAX_DIM
) (
    input  wire logic                                  clk,
    input  wire logic                                  reset,
    input  wire logic                                  clr,
    input  wire logic                                  we,
    input  wire logic [matmul_pkg::CNT_W-1:0]          idx,
    input  wire logic [ELEM_W-1:0]                     wdata,
    output      logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]     q
);
    localparam int N_ELEM = MAX_DIM * MAX_DIM;
    localparam int BUS_W  = ELEM_W * N_ELEM;

    logic [BUS_W-1:0] data_q;
    logic [BUS_W-1:0] data_d;

    // Decode the write index per element slot; indices past the matrix
    // capacity match no slot and are dropped.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (we) begin
            for (int e = 0; e < N_ELEM; e++) begin
                if (int'(idx) == e) begin
                    data_d[e*ELEM_W +: ELEM_W] = wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_loader
//  Description : Accepts a dimension set, streams matrix A then matrix B
//                row-major into flattened registers and requests a multiply.
//                enable stays high until the multiplier reports done.
//                Invalid dimension sets produce a one-cycle err pulse.
//  Ports       : clk   - single clock, rising edge
//                reset - asynchronous, active-low
//                bus   - matrix_loader_if.slave: cfg handshake, element
//                        stream, inA/inB/Ax/Ay/Bx/By/enable/done, busy/err
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_loader #(
    parameter int ELEM_W  = matmul_pkg::ELEM_W,
    parameter int MAX_DIM = matmul_pkg::MAX_DIM
) (
    input  wire logic       clk,
    input  wire logic       reset,
    matrix_loader_if.slave  bus
);
    import matmul_pkg::*;

    loader_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ax_q, ax_d;
    logic [7:0]       ay_q, ay_d;
    logic [7:0]       bx_q, bx_d;
    logic [7:0]       by_q, by_d;
    logic             enable_q, enable_d;
    logic             err_q, err_d;

    logic             cfg_hs;
    logic             s_hs;
    logic             s_ready_w;
    logic             cfg_bad;
    logic [15:0]      a_total;
    logic [15:0]      b_total;
    logic             last_a;
    logic             last_b;
    logic             clr_mats;
    logic             we_a;
    logic             we_b;

    assign s_ready_w = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign cfg_hs    = bus.cfg_valid && (state_q == ST_IDLE);
    assign s_hs      = bus.s_valid && s_ready_w;

    // Inner dimensions must agree: A columns equal B rows.
    assign cfg_bad = !dim_ok(bus.cfg_ax, MAX_DIM) || !dim_ok(bus.cfg_ay, MAX_DIM) ||
                     !dim_ok(bus.cfg_bx, MAX_DIM) || !dim_ok(bus.cfg_by, MAX_DIM) ||
                     (bus.cfg_ax != bus.cfg_by);

    // Element counts; only consulted while loading, where the dims are
    // known to be non-zero so the minus-one cannot wrap.
    assign a_total = 16'(ax_q) * 16'(ay_q);
    assign b_total = 16'(bx_q) * 16'(by_q);
    assign last_a  = (16'(cnt_q) == (a_total - 16'd1));
    assign last_b  = (16'(cnt_q) == (b_total - 16'd1));

    assign we_a = s_hs && (state_q == ST_LOAD_A);
    assign we_b = s_hs && (state_q == ST_LOAD_B);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        bx_d     = bx_q;
        by_d     = by_q;
        enable_d = enable_q;
        err_d    = 1'b0;
        clr_mats = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_hs) begin
                    // Dimensions are latched even when rejected so the
                    // offending set stays visible on Ax/Ay/Bx/By.
                    ax_d     = bus.cfg_ax;
                    ay_d     = bus.cfg_ay;
                    bx_d     = bus.cfg_bx;
                    by_d     = bus.cfg_by;
                    clr_mats = 1'b1;
                    if (cfg_bad) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: begin
                if (s_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_a) begin
                        state_d = ST_LOAD_B;
                    end
                end
            end
            ST_LOAD_B: begin
                if (s_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_b) begin
                        state_d  = ST_RUN;
                        enable_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.done) begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                enable_d = 1'b0;
            end
        endcase

        // Every state entry restarts the element count.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            enable_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            enable_q <= enable_d;
            err_q    <= err_d;
        end
    end

    matrix_elem_writer #(
        .ELEM_W  (ELEM_W),
        .MAX_DIM (MAX_DIM)
    ) u_wr_a (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_mats),
        .we    (we_a),
        .idx   (cnt_q),
        .wdata (bus.s_data),
        .q     (bus.inA)
    );

    matrix_elem_writer #(
        .ELEM_W  (ELEM_W),
        .MAX_DIM (MAX_DIM)
    ) u_wr_b (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_mats),
        .we    (we_b),
        .idx   (cnt_q),
        .wdata (bus.s_data),
        .q     (bus.inB)
    );

    assign bus.cfg_ready = (state_q == ST_IDLE);
    assign bus.s_ready   = s_ready_w;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.err       = err_q;
    assign bus.enable    = enable_q;
    assign bus.Ax        = ax_q;
    assign bus.Ay        = ay_q;
    assign bus.Bx        = bx_q;
    assign bus.By        = by_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_loader
//  Description : Self-checking bench for matrix_loader. Accepted elements are
//                pushed to a scoreboard as they are driven and compared against
//                inA/inB once enable rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_loader;

    localparam int EW = 32;
    localparam int MD = 16;
    localparam int FW = EW * MD * MD;

    typedef struct {
        bit          is_b;
        int          idx;
        logic [31:0] val;
    } exp_t;

    typedef logic [31:0] word_q_t[$];

    logic clk = 1'b0;
    logic reset;

    int n_vec = 0;
    int n_bad = 0;

    exp_t sb[$];

    always #5 clk = ~clk;

    matrix_loader_if #(.ELEM_W(EW), .MAX_DIM(MD)) bus ();

    matrix_loader #(.ELEM_W(EW), .MAX_DIM(MD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------------------------------------------------------- drivers
    task automatic send_cfg(input logic [7:0] ax, input logic [7:0] ay,
                            input logic [7:0] bx, input logic [7:0] by);
        int w = 0;
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_ax    = ax;
        bus.cfg_ay    = ay;
        bus.cfg_bx    = bx;
        bus.cfg_by    = by;
        while (!bus.cfg_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cfg_ready) begin
            n_vec++; n_bad++;
            $display("FAIL cfg_timeout: cfg_ready=%b required 1", bus.cfg_ready);
        end
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    // Streams vals (first na go to A, the rest to B); returns at #1 after the
    // final handshake edge. en_before_last is enable just before that edge.
    task automatic stream(input word_q_t vals, input int na, input int gap_pct,
                          output bit en_before_last);
        int   i = 0;
        int   w = 0;
        exp_t e;
        en_before_last = 1'b0;
        while (i < vals.size()) begin
            @(negedge clk);
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                bus.s_valid = 1'b0;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = vals[i];
            end
            if (bus.s_valid && bus.s_ready) begin
                en_before_last = bus.enable;
                e.is_b = (i >= na);
                e.idx  = (i >= na) ? i - na : i;
                e.val  = vals[i];
                sb.push_back(e);
                i++;
                w = 0;
            end else begin
                w++;
                if (w > 200) begin
                    n_vec++; n_bad++;
                    $display("FAIL stream_timeout: accepted=%0d required=%0d", i, vals.size());
                    break;
                end
            end
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic release_run();
        @(negedge clk);
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
    endtask

    // Pops every expected element and compares it, then compares the whole
    // buses so that any bit outside the loaded elements must be zero.
    task automatic drain_scoreboard(input string tag);
        logic [FW-1:0] ea;
        logic [FW-1:0] eb;
        exp_t          e;
        ea = '0;
        eb = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (e.is_b) begin
                eb[e.idx*EW +: EW] = e.val;
                if (bus.inB[e.idx*EW +: EW] !== e.val) begin
                    n_bad++;
                    $display("FAIL %s inB[%0d]: got %h expected %h", tag, e.idx,
                             bus.inB[e.idx*EW +: EW], e.val);
                end
            end else begin
                ea[e.idx*EW +: EW] = e.val;
                if (bus.inA[e.idx*EW +: EW] !== e.val) begin
                    n_bad++;
                    $display("FAIL %s inA[%0d]: got %h expected %h", tag, e.idx,
                             bus.inA[e.idx*EW +: EW], e.val);
                end
            end
        end
        n_vec++;
        if (bus.inA !== ea) begin
            n_bad++;
            $display("FAIL %s inA_full: %0d bits differ, got low %h expected low %h",
                     tag, $countones(bus.inA ^ ea), bus.inA[127:0], ea[127:0]);
        end
        n_vec++;
        if (bus.inB !== eb) begin
            n_bad++;
            $display("FAIL %s inB_full: %0d bits differ, got low %h expected low %h",
                     tag, $countones(bus.inB ^ eb), bus.inB[127:0], eb[127:0]);
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.enable !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: busy=%b s_ready=%b enable=%b err=%b required 0 0 0 0",
                     bus.busy, bus.s_ready, bus.enable, bus.err);
        end
        n_vec++;
        if (bus.inA !== '0 || bus.inB !== '0) begin
            n_bad++;
            $display("FAIL reset_mats: inA low %h inB low %h required zero", bus.inA[127:0], bus.inB[127:0]);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (bus.cfg_ready !== 1'b1 || {bus.Ax, bus.Ay, bus.Bx, bus.By} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_release: cfg_ready=%b dims=%h required 1 00000000",
                     bus.cfg_ready, {bus.Ax, bus.Ay, bus.Bx, bus.By});
        end
    endtask

    task automatic test_load_2x2();
        word_q_t       v;
        bit            eb;
        logic [FW-1:0] snap_a;
        send_cfg(8'd2, 8'd2, 8'd2, 8'd2);
        v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        stream(v, 4, 0, eb);
        n_vec++;
        if (eb !== 1'b0 || bus.enable !== 1'b1) begin
            n_bad++;
            $display("FAIL load_2x2 enable_latency: before=%b after=%b required 0 1", eb, bus.enable);
        end
        n_vec++;
        if (bus.inA[127:0] !== 128'h00000004_00000003_00000002_00000001) begin
            n_bad++;
            $display("FAIL load_2x2 inA_low: got %h required 00000004000000030000000200000001", bus.inA[127:0]);
        end
        n_vec++;
        if (bus.inB[127:0] !== 128'h00000008_00000007_00000006_00000005) begin
            n_bad++;
            $display("FAIL load_2x2 inB_low: got %h required 00000008000000070000000600000005", bus.inB[127:0]);
        end
        drain_scoreboard("load_2x2");
        // Multiplier slow to finish: everything must hold steady.
        snap_a = bus.inA;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.enable !== 1'b1 || bus.inA !== snap_a || bus.Ax !== 8'd2 || bus.By !== 8'd2) begin
                n_bad++;
                $display("FAIL run_hold cycle %0d: enable=%b Ax=%0d By=%0d inA_stable=%b required 1 2 2 1",
                         c, bus.enable, bus.Ax, bus.By, bus.inA === snap_a);
            end
        end
        release_run();
        n_vec++;
        if (bus.enable !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL run_done: enable=%b cfg_ready=%b busy=%b required 0 1 0",
                     bus.enable, bus.cfg_ready, bus.busy);
        end
    endtask

    task automatic test_mismatch_err();
        send_cfg(8'd3, 8'd2, 8'd4, 8'd2);
        n_vec++;
        if (bus.err !== 1'b1 || bus.s_ready !== 1'b0 || bus.cfg_ready !== 1'b0 || bus.Ax !== 8'd3) begin
            n_bad++;
            $display("FAIL mismatch_err: err=%b s_ready=%b cfg_ready=%b Ax=%0d required 1 0 0 3",
                     bus.err, bus.s_ready, bus.cfg_ready, bus.Ax);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.err !== 1'b0 || bus.s_ready !== 1'b0 || bus.cfg_ready !== 1'b1 ||
            bus.busy !== 1'b0 || bus.Ax !== 8'd3 || bus.By !== 8'd2) begin
            n_bad++;
            $display("FAIL mismatch_return: err=%b s_ready=%b cfg_ready=%b busy=%b Ax=%0d By=%0d required 0 0 1 0 3 2",
                     bus.err, bus.s_ready, bus.cfg_ready, bus.busy, bus.Ax, bus.By);
        end
    endtask

    task automatic test_bad_dims();
        logic [31:0] tbl [4];
        logic [31:0] d;
        tbl[0] = {8'd2,  8'd0, 8'd2,  8'd2};   // Ay zero
        tbl[1] = {8'd0,  8'd2, 8'd2,  8'd0};   // Ax and By zero
        tbl[2] = {8'd17, 8'd1, 8'd1,  8'd17};  // inner dimension too large
        tbl[3] = {8'd2,  8'd2, 8'd17, 8'd2};   // Bx too large
        for (int t = 0; t < 4; t++) begin
            d = tbl[t];
            send_cfg(d[31:24], d[23:16], d[15:8], d[7:0]);
            n_vec++;
            if (bus.err !== 1'b1 || bus.s_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bad_dims[%0d]: err=%b s_ready=%b required 1 0", t, bus.err, bus.s_ready);
            end
            @(posedge clk); #1;
            n_vec++;
            if (bus.err !== 1'b0 || bus.cfg_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL bad_dims_pulse[%0d]: err=%b cfg_ready=%b required 0 1", t, bus.err, bus.cfg_ready);
            end
        end
    endtask

    task automatic test_full_16x16();
        word_q_t v;
        bit      eb;
        for (int i = 0; i < 512; i++) v.push_back($urandom);
        send_cfg(8'd16, 8'd16, 8'd16, 8'd16);
        stream(v, 256, 0, eb);
        n_vec++;
        if (eb !== 1'b0 || bus.enable !== 1'b1) begin
            n_bad++;
            $display("FAIL full_16x16 enable: before=%b after=%b required 0 1", eb, bus.enable);
        end
        drain_scoreboard("full_16x16");
        release_run();
        n_vec++;
        if (bus.cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL full_16x16 idle: cfg_ready=%b required 1", bus.cfg_ready);
        end
    endtask

    task automatic test_random_valid();
        word_q_t v;
        bit      eb;
        for (int i = 0; i < 18; i++) v.push_back($urandom);
        send_cfg(8'd3, 8'd2, 8'd4, 8'd3);
        stream(v, 6, 40, eb);
        n_vec++;
        if (eb !== 1'b0 || bus.enable !== 1'b1) begin
            n_bad++;
            $display("FAIL random_valid enable: before=%b after=%b required 0 1", eb, bus.enable);
        end
        drain_scoreboard("random_valid");
        release_run();
    endtask

    task automatic test_reset_mid_load();
        word_q_t v;
        bit      eb;
        send_cfg(8'd2, 8'd2, 8'd2, 8'd2);
        v = '{32'd11, 32'd22, 32'd33};
        stream(v, 4, 0, eb);
        // done outside RUN has no effect
        release_run();
        n_vec++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b1 || bus.enable !== 1'b0) begin
            n_bad++;
            $display("FAIL done_ignored: s_ready=%b busy=%b enable=%b required 1 1 0",
                     bus.s_ready, bus.busy, bus.enable);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.inA !== '0 || bus.Ax !== 8'd0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%b s_ready=%b inA low %h Ax=%0d required 0 0 0 0",
                     bus.busy, bus.s_ready, bus.inA[127:0], bus.Ax);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        send_cfg(8'd1, 8'd1, 8'd1, 8'd1);
        v = '{32'd7, 32'd9};
        stream(v, 1, 0, eb);
        n_vec++;
        if (eb !== 1'b0 || bus.enable !== 1'b1) begin
            n_bad++;
            $display("FAIL load_1x1 enable: before=%b after=%b required 0 1", eb, bus.enable);
        end
        n_vec++;
        if (bus.inA !== {{(FW-32){1'b0}}, 32'd7} || bus.inB !== {{(FW-32){1'b0}}, 32'd9}) begin
            n_bad++;
            $display("FAIL load_1x1 bus: inA low %h inB low %h required 7 and 9 with zero upper bits",
                     bus.inA[127:0], bus.inB[127:0]);
        end
        drain_scoreboard("load_1x1");
        release_run();
    endtask

    // -------------------------------------------------------------- sequence
    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_ax    = '0;
        bus.cfg_ay    = '0;
        bus.cfg_bx    = '0;
        bus.cfg_by    = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.done      = 1'b0;
        reset         = 1'b0;

        test_reset();
        test_load_2x2();
        test_mismatch_err();
        test_bad_dims();
        test_full_16x16();
        test_random_valid();
        test_reset_mid_load();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
